// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encoding,
// default operand width and the bit-counter width helper.
package mult_pkg;

    // Default operand width in bits (legal range 2..32).
    localparam int DEFAULT_WIDTH = 8;

    // Controller states: wait for start, accumulate partial products, finish.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Width of the bit counter. It only has to reach WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/mult_twos_negate.sv
// Combinational two's-complement negation. It is used both to take operand
// magnitudes and to apply the result sign.
module mult_twos_negate #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val
);

    // Invert and add one.
    assign o_val = ~i_val + W'(1);

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier. One multiplier bit is retired per clock,
// LSB first, followed by a sign-fix cycle. Signed operands are multiplied as
// magnitudes, and the product is negated at the end when the signs differ.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int SIGNED_SUPPORT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int             PW       = 2 * WIDTH;
    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    // Signed operation is only possible when the feature is built in.
    logic             w_signed_op;
    logic [WIDTH-1:0] w_a_neg;
    logic [WIDTH-1:0] w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [PW-1:0]    w_acc_neg;

    state_t           r_state;
    logic [PW-1:0]    r_mcand;   // multiplicand, pre-shifted by the current bit index
    logic [WIDTH-1:0] r_mplier;  // multiplier, shifted right so bit 0 is the current bit
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    r_acc;
    logic             r_sign;
    logic [PW-1:0]    r_p;
    logic             r_done;
    logic             r_busy;

    assign w_signed_op = (SIGNED_SUPPORT != 0) ? signed_mode : 1'b0;

    mult_twos_negate #(.W(WIDTH)) u_neg_a (.i_val(a),     .o_val(w_a_neg));
    mult_twos_negate #(.W(WIDTH)) u_neg_b (.i_val(b),     .o_val(w_b_neg));
    mult_twos_negate #(.W(PW))    u_neg_p (.i_val(r_acc), .o_val(w_acc_neg));

    // Operand magnitudes. Negating -2^(WIDTH-1) yields the same bit pattern,
    // which is the correct magnitude when it is read as unsigned.
    assign w_a_mag = (w_signed_op && a[WIDTH-1]) ? w_a_neg : a;
    assign w_b_mag = (w_signed_op && b[WIDTH-1]) ? w_b_neg : b;

    // Controller and datapath: latch on start, add one partial product per
    // RUN cycle, then apply the sign and publish the result in FIX.
    // NOTE: state registers use non-blocking (<=) assignments so every
    // register samples the pre-edge values, just as the flops in hardware do.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register here, including the datapath, is reset. There
        // is no memory array, and an abort must leave p at zero.
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_sign   <= 1'b0;
            r_p      <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_sign   <= w_signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == LAST_BIT) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_p     <= r_sign ? w_acc_neg : r_acc;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign p    = r_p;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier. It drives an 8-bit and a
// 16-bit instance and compares their results with an arithmetic reference.
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] p8;

    logic        start16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [31:0] p16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    shift_add_multiplier #(.WIDTH(8), .SIGNED_SUPPORT(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8)
    );

    shift_add_multiplier #(.WIDTH(16), .SIGNED_SUPPORT(1)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .p(p16)
    );

    // Reference product: interpret the operands as integers and multiply,
    // then keep the low 2*w bits.
    function automatic logic [31:0] ref_mul(input int w, input bit sm,
                                            input logic [15:0] a, input logic [15:0] b);
        longint x, y, prod, mask;
        x = longint'(a) & ((longint'(1) << w) - 1);
        y = longint'(b) & ((longint'(1) << w) - 1);
        if (sm && x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
        if (sm && y >= (longint'(1) << (w - 1))) y = y - (longint'(1) << w);
        prod = x * y;
        mask = (longint'(1) << (2 * w)) - 1;
        return 32'(prod & mask);
    endfunction

    // Issue one multiply and wait for done. lat counts edges after the
    // accepting edge (-1 means done never came).
    task automatic do_mul(input bit wide, input bit sm, input logic [15:0] a,
                          input logic [15:0] b, output logic [31:0] p, output int lat,
                          output logic busy_acc, output logic busy_done);
        @(negedge clk);
        if (wide) begin
            start16 = 1'b1; sm16 = sm; a16 = a; b16 = b;
        end else begin
            start8 = 1'b1; sm8 = sm; a8 = a[7:0]; b8 = b[7:0];
        end
        @(posedge clk); #1;
        busy_acc = wide ? busy16 : busy8;
        @(negedge clk);
        start8 = 1'b0; start16 = 1'b0;
        // Scramble the operands so that the result depends on the latched values.
        a8 = ~a[7:0]; b8 = ~b[7:0]; sm8 = ~sm;
        a16 = ~a; b16 = ~b; sm16 = ~sm;
        lat = -1; p = '0; busy_done = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (wide ? done16 : done8) begin
                lat = cyc;
                p = wide ? p16 : {16'h0000, p8};
                busy_done = wide ? busy16 : busy8;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (p8 !== 16'h0) begin errors++; $display("FAIL reset_p8: got %h expected 0000", p8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy8: got %b expected 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done8: got %b expected 0", done8); end
        checks++; if (p16 !== 32'h0) begin errors++; $display("FAIL reset_p16: got %h expected 0", p16); end
        checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL reset_busy16: got %b expected 0", busy16); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_back_to_back();
        logic [31:0] p; int lat; logic ba, bd;
        do_mul(1'b0, 1'b0, 16'd5, 16'd5, p, lat, ba, bd);
        checks++; if (lat != 9) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 9", lat); end
        checks++; if (p[15:0] !== 16'h0019) begin errors++; $display("FAIL b2b_first_p: got %h expected 0019", p[15:0]); end
        checks++; if (ba !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b expected 1", ba); end
        checks++; if (bd !== 1'b0) begin errors++; $display("FAIL busy_with_done: got %b expected 0", bd); end
        // Issued inside the done cycle of the previous multiply.
        do_mul(1'b0, 1'b0, 16'd100, 16'd2, p, lat, ba, bd);
        checks++; if (lat != 9) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 9", lat); end
        checks++; if (p[15:0] !== 16'h00C8) begin errors++; $display("FAIL b2b_second_p: got %h expected 00c8", p[15:0]); end
        @(posedge clk); #1;
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL done_single_cycle: got %b expected 0", done8); end
        checks++; if (p8 !== 16'h00C8) begin errors++; $display("FAIL p_hold: got %h expected 00c8", p8); end
    endtask

    task automatic test_corners();
        logic [31:0] p; int lat; logic ba, bd;
        logic        t_sm [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0]  t_a  [7] = '{8'hFF, 8'h80, 8'hFD, 8'hFF, 8'h00, 8'h80, 8'h80};
        logic [7:0]  t_b  [7] = '{8'hFF, 8'h80, 8'h05, 8'hFF, 8'h00, 8'h7F, 8'h80};
        logic [15:0] t_e  [7] = '{16'hFE01, 16'h4000, 16'hFFF1, 16'h0001, 16'h0000, 16'hC080, 16'h4000};
        for (int i = 0; i < 7; i++) begin
            do_mul(1'b0, t_sm[i], {8'h00, t_a[i]}, {8'h00, t_b[i]}, p, lat, ba, bd);
            checks++;
            if (p[15:0] !== t_e[i] || lat != 9) begin
                errors++;
                $display("FAIL corner_%0d: got p=%h lat=%0d expected p=%h lat=9", i, p[15:0], lat, t_e[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0; int lat = -1; logic [15:0] pv = '0;
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b0; a8 = 8'd7; b8 = 8'd9;
        @(posedge clk); #1;
        @(negedge clk);
        start8 = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            if (done8) begin
                ndone++;
                if (lat < 0) begin lat = cyc; pv = p8; end
            end
            if (cyc == 3) begin
                @(negedge clk);
                start8 = 1'b1; sm8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
            end else if (cyc == 4) begin
                @(negedge clk);
                start8 = 1'b0;
            end
        end
        checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", ndone); end
        checks++; if (lat != 9) begin errors++; $display("FAIL ignore_latency: got %0d expected 9", lat); end
        checks++; if (pv !== 16'd63) begin errors++; $display("FAIL ignore_p: got %h expected 003f", pv); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] p; int lat; logic ba, bd; int ndone = 0;
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b0; a8 = 8'd200; b8 = 8'd3;
        @(posedge clk); #1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (p8 !== 16'h0) begin errors++; $display("FAIL abort_p: got %h expected 0000", p8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy8); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clk); #1;
            if (done8) ndone++;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", ndone); end
        checks++; if (p8 !== 16'h0) begin errors++; $display("FAIL abort_p_held: got %h expected 0000", p8); end
        do_mul(1'b0, 1'b1, 16'h00C8, 16'h0003, p, lat, ba, bd);
        checks++;
        if (p[15:0] !== ref_mul(8, 1'b1, 16'h00C8, 16'h0003) || lat != 9) begin
            errors++;
            $display("FAIL after_abort: got p=%h lat=%0d expected p=%h lat=9",
                     p[15:0], lat, ref_mul(8, 1'b1, 16'h00C8, 16'h0003));
        end
    endtask

    task automatic test_sweep16();
        logic [31:0] p, exp; int lat; logic ba, bd;
        logic [15:0] ea, eb; bit sm;
        for (int i = 0; i < 1000; i++) begin
            sm = 1'($urandom_range(0, 1));
            case (i)
                0: begin ea = 16'h8000; eb = 16'h8000; end
                1: begin ea = 16'hFFFF; eb = 16'hFFFF; end
                2: begin ea = 16'h0000; eb = 16'hFFFF; end
                3: begin ea = 16'h8000; eb = 16'h7FFF; end
                default: begin ea = 16'($urandom); eb = 16'($urandom); end
            endcase
            exp = ref_mul(16, sm, ea, eb);
            do_mul(1'b1, sm, ea, eb, p, lat, ba, bd);
            checks++;
            if (p !== exp || lat != 17 || bd !== 1'b0) begin
                errors++;
                $display("FAIL sweep16_%0d: sm=%0d a=%h b=%h got p=%h lat=%0d busy=%b expected p=%h lat=17 busy=0",
                         i, sm, ea, eb, p, lat, bd, exp);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_back_to_back();
        test_corners();
        test_ignore_start();
        test_reset_mid();
        test_sweep16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
